fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be: BITWIDTH, 32, datapath/address width; RST_VALUE, 32'h80000000, PC after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  instruction memory accepts request.
REQ-006 imem_req_addr  output  BITWIDTH  fetch address; SHALL equal current PC.
REQ-007 imem_resp_valid  input  1  fetch data returned, one-cycle pulse.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 imem_resp_err  input  1  access fault flag for the response.
REQ-010 inst_valid  output  1  instruction available to decode.
REQ-011 inst_ready  input  1  decode consumes instruction.
REQ-012 inst  output  32  buffered instruction word.
REQ-013 inst_pc  output  BITWIDTH  PC of buffered instruction.
REQ-014 inst_err  output  1  buffered fault flag.
REQ-015 redirect_valid  input  1  jump/branch/trap redirect, single-cycle pulse.
REQ-016 redirect_pc  input  BITWIDTH  redirect target.
REQ-017 fetch_cnt  output  32  count of instructions handed to decode.

Function
REQ-018 State machine SHALL have states IDLE, REQ, WAIT, HOLD, plus a 1-bit drop flag.
REQ-019 IDLE: all valids 0; SHALL go to REQ unconditionally next cycle.
REQ-020 REQ: imem_req_valid=1, imem_req_addr=pc; on valid&&ready SHALL go WAIT; else stay REQ with address stable.
REQ-021 WAIT: on imem_resp_valid with drop=0, SHALL latch data/err/pc into inst/inst_err/inst_pc and go HOLD.
REQ-022 WAIT: on imem_resp_valid with drop=1, SHALL discard the response, clear drop, go REQ.
REQ-023 HOLD: inst_valid=1, inst/inst_pc/inst_err stable; on inst_valid&&inst_ready SHALL set pc<=pc+4, fetch_cnt+=1, go REQ.
REQ-024 Latency: request issued at most 1 cycle after HOLD handshake; inst_valid asserts the cycle after resp_valid.
REQ-025 pc+4 and fetch_cnt SHALL wrap modulo 2^BITWIDTH and 2^32 respectively, no saturation.
REQ-026 redirect_pc[1:0] SHALL be forced to 2'b00 when loaded.
REQ-027 Redirect has priority over all non-reset events; in every case pc<=redirect_pc (aligned).
REQ-028 Redirect in IDLE: pc updated, go REQ.
REQ-029 Redirect in REQ without handshake: pc updated, stay REQ; imem_req_addr SHALL change next cycle (only permitted address change while unaccepted).
REQ-030 Redirect in REQ with handshake same cycle: go WAIT with drop=1.
REQ-031 Redirect in WAIT without resp_valid: stay WAIT with drop=1.
REQ-032 Redirect in WAIT with resp_valid same cycle: response discarded, drop=0, go REQ.
REQ-033 Redirect in HOLD with inst_ready same cycle: handshake completes, fetch_cnt+=1, next pc=redirect_pc (not pc+4), go REQ.
REQ-034 Redirect in HOLD without inst_ready: buffered instruction discarded, inst_valid=0 next cycle, fetch_cnt unchanged, go REQ.
REQ-035 imem_resp_valid outside WAIT SHALL be ignored with no state change.
REQ-036 Second redirect while drop=1 SHALL update pc only; drop stays 1 (exactly one outstanding response is dropped).

Reset
REQ-037 rst=1 at posedge SHALL set pc=RST_VALUE, state=IDLE, drop=0, fetch_cnt=0, inst=0, inst_pc=0, inst_err=0, overriding redirects and handshakes in that cycle.
REQ-038 During and one cycle after rst, imem_req_valid=0 and inst_valid=0; reset mid-WAIT SHALL NOT capture the late response.

Verification
REQ-039 Release rst, imem_req_ready=1, 1-cycle response latency -> addr 0x80000000, then 0x80000004, 0x80000008; fetch_cnt=3 after three inst handshakes.
REQ-040 Hold imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and addr stable at 0x80000000 throughout.
REQ-041 Redirect to 0x80001002 during WAIT, response 0xDEADBEEF arrives 2 cycles later -> response dropped, next request addr 0x80001000, fetch_cnt unchanged.
REQ-042 In HOLD, inst_ready=1 with redirect to 0x80000100 same cycle -> fetch_cnt+1, next request addr 0x80000100.
REQ-043 pc=0xFFFFFFFC accepted by decode -> next addr 0x00000000; imem_resp_err=1 -> inst_err=1 with that instruction.
REQ-044 Assert rst in WAIT, response arrives the following cycle -> inst_valid stays 0, next request addr 0x80000000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry
// decode buffer, redirect handling with single-response drop.
module fetch_ctrl #(
  parameter int unsigned         BITWIDTH  = 32,
  parameter logic [BITWIDTH-1:0] RST_VALUE = 32'h80000000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [BITWIDTH-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [31:0]         imem_resp_data,
  input  logic                imem_resp_err,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [BITWIDTH-1:0] inst_pc,
  output logic                inst_err,
  input  logic                redirect_valid,
  input  logic [BITWIDTH-1:0] redirect_pc,
  output logic [31:0]         fetch_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t              r_state, w_state_n;
  logic                r_drop, w_drop_n;
  logic [BITWIDTH-1:0] r_pc, w_pc_n;
  logic [31:0]         r_inst, w_inst_n;
  logic [BITWIDTH-1:0] r_inst_pc, w_inst_pc_n;
  logic                r_inst_err, w_inst_err_n;
  logic [31:0]         r_cnt, w_cnt_n;
  logic [BITWIDTH-1:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc[BITWIDTH-1:2], 2'b00};

  always_comb begin
    w_state_n    = r_state;
    w_drop_n     = r_drop;
    w_pc_n       = r_pc;
    w_inst_n     = r_inst;
    w_inst_pc_n  = r_inst_pc;
    w_inst_err_n = r_inst_err;
    w_cnt_n      = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_state_n = S_REQ;
      end
      S_REQ: begin
        if (imem_req_ready) begin
          w_state_n = S_WAIT;
          if (redirect_valid) w_drop_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid || r_drop) begin
            w_drop_n  = 1'b0;
            w_state_n = S_REQ;
          end else begin
            w_inst_n     = imem_resp_data;
            w_inst_pc_n  = r_pc;
            w_inst_err_n = imem_resp_err;
            w_state_n    = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_drop_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          w_cnt_n   = r_cnt + 32'd1;
          w_pc_n    = r_pc + BITWIDTH'(4);
          w_state_n = S_REQ;
        end else if (redirect_valid) begin
          w_state_n = S_REQ;
        end
      end
    endcase
    // A redirect target always wins over the sequential pc
    if (redirect_valid) w_pc_n = w_redir_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_drop     <= 1'b0;
      r_pc       <= RST_VALUE;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_inst_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_drop     <= w_drop_n;
      r_pc       <= w_pc_n;
      r_inst     <= w_inst_n;
      r_inst_pc  <= w_inst_pc_n;
      r_inst_err <= w_inst_err_n;
      r_cnt      <= w_cnt_n;
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_HOLD);
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign inst_err       = r_inst_err;
  assign fetch_cnt      = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: scoreboarded fetches, stalls,
// redirects in each state, wrap-around and reset mid-transaction.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = '0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  fetch_ctrl #(
    .BITWIDTH (32),
    .RST_VALUE(32'h80000000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_valid_wait", {31'd0, imem_req_valid}, 32'd1);
  endtask

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                           input logic err, input logic redir,
                           input logic [31:0] rpc);
    exp_t e;
    wait_req();
    chk("req_addr", imem_req_addr, addr);
    sb.push_back('{pc: addr, data: data, err: err});
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    chk("inst_valid", {31'd0, inst_valid}, 32'd1);
    if (inst_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("inst", inst, e.data);
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_err", {31'd0, inst_err}, {31'd0, e.err});
    end
    inst_ready     = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    exp_cnt        = exp_cnt + 32'd1;
    chk("fetch_cnt", fetch_cnt, exp_cnt);
    chk("req_after_hs", {31'd0, imem_req_valid}, 32'd1);
    chk("next_addr", imem_req_addr,
        redir ? {rpc[31:2], 2'b00} : addr + 32'd4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    exp_cnt = '0;
    rst = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", {31'd0, inst_err}, 32'd0);
    do_reset();
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Straight-line fetch of three instructions
    fetch_one(32'h80000000, 32'h00000013, 1'b0, 1'b0, '0);
    fetch_one(32'h80000004, 32'h00100093, 1'b0, 1'b0, '0);
    fetch_one(32'h80000008, 32'h00208113, 1'b0, 1'b0, '0);
    chk("cnt_three", fetch_cnt, 32'd3);

    // Back-pressure on the request channel
    do_reset();
    wait_req();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_req_addr, 32'h80000000);
      step();
    end
    fetch_one(32'h80000000, 32'hA5A5A5A5, 1'b0, 1'b0, '0);

    // Redirect while waiting: response must be dropped
    wait_req();
    chk("w_addr", imem_req_addr, 32'h80000004);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80001002;
    step();
    redirect_valid = 1'b0;
    chk("w_drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEADBEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("drop_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("drop_addr", imem_req_addr, 32'h80001000);
    chk("drop_cnt", fetch_cnt, exp_cnt);

    // Decode handshake with redirect in the same cycle
    fetch_one(32'h80001000, 32'h11111111, 1'b0, 1'b1, 32'h80000100);

    // Redirect in REQ without acceptance, then wrap-around
    wait_req();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFF;
    step();
    redirect_valid = 1'b0;
    chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'hFFFFFFFC);
    fetch_one(32'hFFFFFFFC, 32'h12345678, 1'b1, 1'b0, '0);
    fetch_one(32'h00000000, 32'h87654321, 1'b0, 1'b0, '0);

    // Reset in WAIT with a late response
    wait_req();
    chk("r_addr", imem_req_addr, 32'h00000004);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    do_reset();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hCAFEF00D;
    step();
    imem_resp_valid = 1'b0;
    chk("late_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("late_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("late_addr", imem_req_addr, 32'h80000000);
    chk("late_inst", inst, 32'd0);

    // Redirect in HOLD without decode acceptance
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0BADF00D;
    step();
    imem_resp_valid = 1'b0;
    chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("hold_inst", inst, 32'h0BADF00D);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80000200;
    step();
    redirect_valid = 1'b0;
    chk("hkill_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("hkill_cnt", fetch_cnt, exp_cnt);
    chk("hkill_addr", imem_req_addr, 32'h80000200);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
